// File: rtl/thermal_pixel_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : thermal_pixel_sequencer_if
// Description : Float pixel output stream (valid/ready with index and last).
// Revision    : 1.0 - initial release
// ============================================================================
interface thermal_pixel_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/thermal_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : thermal_pixel_sequencer
// Description : Reads one frame of signed 16-bit pixels, subtracts a global
//               offset with saturation, paces the int16->float converter and
//               streams the float results through an output FIFO.
//               PIXELS must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module thermal_pixel_sequencer #(
  parameter int PIXELS     = 768,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  wire                clk,
  input  wire                resetn,
  input  wire                start,
  input  wire  [15:0]        offset,
  output logic               busy,
  output logic               done,
  output logic               ram_rd_en,
  output logic [ADDR_W-1:0]  ram_addr,
  input  wire  [15:0]        ram_rdata,
  output logic [15:0]        int_out,
  input  wire  [31:0]        float_in,
  thermal_pixel_sequencer_if.master out_if
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int STAGES  = 4;  // issue cycle + 4 = converter result capture cycle
  localparam int ENTRY_W = 1 + ADDR_W + 32;

  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [15:0]         offset_q, offset_d;
  logic [ADDR_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [STAGES:1]     pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0]   pipe_idx_q [1:STAGES];
  logic [ADDR_W-1:0]   pipe_idx_d [1:STAGES];
  logic [15:0]         int_q, int_d;
  logic [ENTRY_W-1:0]  fifo_mem_q [0:FIFO_DEPTH-1];
  logic [ENTRY_W-1:0]  fifo_mem_d [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                done_q, done_d;

  logic [2:0]          inflight;
  logic [CNT_W:0]      occupancy;
  logic                start_go;
  logic                issue_go;
  logic signed [16:0]  diff;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  head;

  assign head             = fifo_mem_q[rd_ptr_q];
  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_data  = head[31:0];
  assign out_if.out_index = head[32 +: ADDR_W];
  assign out_if.out_last  = head[ENTRY_W-1];
  assign ram_rd_en        = rd_en_q;
  assign ram_addr         = addr_q;
  assign int_out          = int_q;
  assign push             = pipe_vld_q[STAGES];
  assign pop              = out_if.out_valid && out_if.out_ready;

  // Issue control: spaced reads, only while the FIFO can hold everything in flight
  always_comb begin
    inflight = {2'b00, rd_en_q};
    for (int s = 1; s <= STAGES; s++) begin
      inflight = inflight + {2'b00, pipe_vld_q[s]};
    end
    occupancy = {1'b0, count_q} + {{(CNT_W - 2){1'b0}}, inflight};
    start_go  = (state_q == S_IDLE) && start;
    issue_go  = start_go || ((state_q == S_RUN) && !rd_en_q && (occupancy < DEPTH_C));
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue_go && (issue_cnt_q == LAST_IDX)) state_d = S_DRAIN;
      S_DRAIN: if (pop && head[ENTRY_W-1]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers the frame plus the done cycle
  always_comb begin
    busy = (state_q != S_IDLE) || done_q;
    done = done_q;
  end

  // Datapath next-state: read issue, tag pipeline, saturating subtract, FIFO
  always_comb begin
    offset_d    = start_go ? offset : offset_q;
    issue_cnt_d = issue_cnt_q;
    addr_d      = addr_q;
    rd_en_d     = issue_go;
    if (start_go) begin
      issue_cnt_d = ADDR_W'(1);
      addr_d      = '0;
    end else if (issue_go) begin
      issue_cnt_d = issue_cnt_q + ADDR_W'(1);
      addr_d      = issue_cnt_q;
    end

    pipe_vld_d    = {pipe_vld_q[STAGES-1:1], rd_en_q};
    pipe_idx_d[1] = addr_q;
    for (int s = 2; s <= STAGES; s++) begin
      pipe_idx_d[s] = pipe_idx_q[s-1];
    end

    // RAM data is present one cycle after the read; load the converter input then
    diff  = $signed({ram_rdata[15], ram_rdata}) - $signed({offset_q[15], offset_q});
    int_d = int_q;
    if (pipe_vld_q[1]) begin
      if (diff[16] != diff[15]) int_d = diff[16] ? 16'h8000 : 16'h7FFF;
      else                      int_d = diff[15:0];
    end

    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = {(pipe_idx_q[STAGES] == LAST_IDX), pipe_idx_q[STAGES], float_in};
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    done_d = (state_q == S_DRAIN) && pop && head[ENTRY_W-1];
  end

  // Datapath registers; reset aborts the frame and flushes everything
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      offset_q    <= '0;
      issue_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      pipe_vld_q  <= '0;
      pipe_idx_q  <= '{default: '0};
      int_q       <= '0;
      fifo_mem_q  <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      offset_q    <= offset_d;
      issue_cnt_q <= issue_cnt_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_idx_q  <= pipe_idx_d;
      int_q       <= int_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      done_q      <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_thermal_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_thermal_pixel_sequencer
// Description : Scoreboard bench for thermal_pixel_sequencer with RAM and
//               two-cycle int16->float converter models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thermal_pixel_sequencer;
  localparam int PIXELS     = 768;
  localparam int ADDR_W     = 10;
  localparam int FIFO_DEPTH = 8;

  logic              clk    = 1'b0;
  logic              resetn = 1'b1;
  logic              start  = 1'b0;
  logic [15:0]       offset = 16'h0;
  logic              busy, done, ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_rdata = 16'h0;
  logic [15:0]       int_out;
  logic [31:0]       float_in;

  thermal_pixel_sequencer_if #(.ADDR_W(ADDR_W)) out_if ();

  thermal_pixel_sequencer #(.PIXELS(PIXELS), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .resetn(resetn), .start(start), .offset(offset),
    .busy(busy), .done(done), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .int_out(int_out), .float_in(float_in), .out_if(out_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   ramp_chk = 0;

  logic [15:0] ram [0:1023];
  logic [15:0] cv_a = 16'h0, cv_b = 16'h0;

  function automatic logic [15:0] sat16(input logic [15:0] r, input logic [15:0] o);
    int d;
    d = int'($signed(r)) - int'($signed(o));
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return d[15:0];
  endfunction

  function automatic logic [31:0] i2f(input logic [15:0] v);
    logic [15:0] mag;
    logic [31:0] sh;
    int p;
    if (v == 16'h0) return 32'h0;
    mag = v[15] ? (~v + 16'h1) : v;
    p = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) p = i;
    sh = {16'h0, mag} << (23 - p);
    return {v[15], 8'(127 + p), sh[22:0]};
  endfunction

  // Frame RAM: registered read
  always @(posedge clk) if (ram_rd_en) ram_rdata <= ram[ram_addr];

  // Converter: result valid only if the input was stable for the two prior cycles
  always @(posedge clk) begin
    cv_a <= int_out;
    cv_b <= cv_a;
  end
  assign float_in = (cv_a == cv_b) ? i2f(cv_a) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  // Monitor: pop and compare whenever the DUT hands over a pixel
  always @(negedge clk) begin
    if (resetn && out_if.out_valid && out_if.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got index %0d required none", out_if.out_index);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_index", 64'(out_if.out_index), 64'(mon_e.idx));
        check("out_data",  64'(out_if.out_data),  64'(mon_e.data));
        check("out_last",  64'(out_if.out_last),  64'(mon_e.last));
      end
      if (ramp_chk && out_if.out_index == 10'd0)   check("ramp_idx0",   64'(out_if.out_data), 64'h0000_0000_C3C0_0000);
      if (ramp_chk && out_if.out_index == 10'd384) check("ramp_idx384", 64'(out_if.out_data), 64'h0);
      if (ramp_chk && out_if.out_index == 10'd385) check("ramp_idx385", 64'(out_if.out_data), 64'h0000_0000_3F80_0000);
    end
  end

  int          first_valid, done_rel, n_done, busy_fall, n_rd, b2b, rd_at_release;
  logic        snap_busy [0:7];
  logic        snap_rd   [0:7];
  logic [9:0]  snap_addr [0:7];
  logic [15:0] snap_int  [0:7];

  // ready_mode: 0 = always ready, 1 = held low until release_rel, 2 = random
  task automatic do_frame(input logic [15:0] off, input int stop_rel, input int ready_mode,
                          input int release_rel, input int restart_rel);
    exp_t e;
    logic prev_rd;
    first_valid = -1; done_rel = -1; n_done = 0; busy_fall = -1;
    n_rd = 0; b2b = 0; rd_at_release = -1; prev_rd = 1'b0;
    for (int k = 0; k < PIXELS; k++) begin
      e.data = i2f(sat16(ram[k], off));
      e.idx  = ADDR_W'(k);
      e.last = (k == PIXELS - 1);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1;
    offset = off;
    out_if.out_ready = (ready_mode == 1) ? 1'b0 : 1'b1;
    for (int rel = 0; rel < 6000; rel++) begin
      @(negedge clk);
      if (rel < 8) begin
        snap_busy[rel] = busy; snap_rd[rel] = ram_rd_en;
        snap_addr[rel] = ram_addr; snap_int[rel] = int_out;
      end
      if (first_valid < 0 && out_if.out_valid) first_valid = rel;
      if (ram_rd_en) begin
        n_rd++;
        if (prev_rd) b2b++;
      end
      prev_rd = ram_rd_en;
      if (done) begin
        n_done++;
        if (done_rel < 0) done_rel = rel;
      end
      if (busy_fall < 0 && rel > 0 && !busy) busy_fall = rel;
      if (ready_mode == 1 && rel == release_rel - 1) rd_at_release = n_rd;
      if (stop_rel > 0 && rel == stop_rel) return;
      if (done_rel >= 0 && rel == done_rel + 1) return;
      @(posedge clk); #1;
      start = (rel + 1 == restart_rel);
      if (start) offset = ~off;
      if (ready_mode == 1) out_if.out_ready = (rel + 1 >= release_rel);
      if (ready_mode == 2) out_if.out_ready = 1'($urandom_range(0, 1));
    end
    n_cmp++;
    n_err++;
    $display("FAIL frame_timeout: got no done required done within 6000 cycles");
  endtask

  task automatic frame_checks(input string tag);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_reads"},       64'(n_rd), 64'(PIXELS));
    check({tag, "_spacing"},     64'(b2b), 64'd0);
    check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 1024; k++) ram[k] = 16'(k - 384);
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({busy, done, ram_rd_en, out_if.out_valid, out_if.out_last}), 64'd0);
    check("reset_bus",  64'({ram_addr, int_out, out_if.out_index}), 64'd0);
    check("reset_data", 64'(out_if.out_data), 64'd0);
    resetn = 1'b1;

    // Ramp frame, always ready
    ramp_chk = 1;
    do_frame(16'h0000, 0, 0, 0, 0);
    ramp_chk = 0;
    check("busy_cycle0", 64'(snap_busy[0]), 64'd0);
    check("busy_cycle1", 64'(snap_busy[1]), 64'd1);
    check("read_cycle1", 64'({snap_rd[1], snap_addr[1]}), {53'd0, 1'b1, 10'd0});
    check("read_cycle2", 64'(snap_rd[2]), 64'd0);
    check("read_cycle3", 64'({snap_rd[3], snap_addr[3]}), {53'd0, 1'b1, 10'd1});
    check("first_valid", 64'(first_valid), 64'd6);
    check("done_cycle",  64'(done_rel), 64'd1541);
    check("busy_fall",   64'(busy_fall), 64'd1542);
    frame_checks("ramp");

    // Saturation, positive then negative
    ram[0] = 16'h7FFF;
    do_frame(16'hFFFE, 8, 0, 0, 0);
    check("sat_hi_c3", 64'(snap_int[3]), 64'h7FFF);
    check("sat_hi_c4", 64'(snap_int[4]), 64'h7FFF);
    do_reset();
    ram[1] = 16'h8000;
    do_frame(16'h0001, 8, 0, 0, 0);
    check("sat_pix0_c3", 64'(snap_int[3]), 64'h7FFE);
    check("sat_lo_c5",   64'(snap_int[5]), 64'h8000);
    check("sat_lo_c6",   64'(snap_int[6]), 64'h8000);
    do_reset();
    ram[0] = 16'(-384);
    ram[1] = 16'(-383);

    // Backpressure from cycle 0, released at cycle 80
    do_frame(16'h0100, 0, 1, 80, 0);
    check("bp_reads_when_full", 64'(rd_at_release), 64'(FIFO_DEPTH));
    frame_checks("bp");

    // Random ready, extra start (with a different offset) during RUN
    do_frame(16'h8000, 0, 2, 0, 200);
    frame_checks("rand");

    // Mid-frame asynchronous reset, then restart
    do_frame(16'd100, 400, 0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({busy, done, ram_rd_en, out_if.out_valid, out_if.out_last}), 64'd0);
    check("async_rst_bus",  64'({ram_addr, int_out, out_if.out_index}), 64'd0);
    check("async_rst_data", 64'(out_if.out_data), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    do_frame(16'd100, 0, 0, 0, 0);
    check("restart_first_valid", 64'(first_valid), 64'd6);
    frame_checks("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/thermal_pixel_sequencer.md
# thermal_pixel_sequencer

Walks one thermal frame of signed 16-bit raw pixel words stored in the frame RAM. It subtracts a global offset with signed saturation and presents each result to the downstream `int16_to_float` converter on a paced, held input. It captures the converter's 32-bit float result into an output FIFO and streams floats out with valid/ready, index and last flags. It sits between the frame RAM and the float-consuming display/packing path.

## Interface
- `PIXELS`, 768: pixels per frame.
- `ADDR_W`, 10: RAM address and index width; must satisfy 2^ADDR_W ≥ PIXELS.
- `FIFO_DEPTH`, 8: output FIFO entries; minimum 4, power of two.

- `clk` in 1: single system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: begin one frame; sampled only in IDLE.
- `offset` in 16: signed offset; sampled once when `start` is accepted.
- `busy` out 1: high from the cycle after `start` is accepted until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse after the last pixel is accepted downstream.
- `ram_rd_en` out 1: frame RAM read strobe.
- `ram_addr` out ADDR_W: frame RAM read address.
- `ram_rdata` in 16: RAM data, valid the cycle after `ram_rd_en`.
- `int_out` out 16: signed value driving the converter input.
- `float_in` in 32: converter output.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accept.
- `out_data` out 32: float pixel.
- `out_index` out ADDR_W: pixel index of `out_data`.
- `out_last` out 1: high with index PIXELS-1.

## Operation
- FSM states are IDLE, RUN and DRAIN.
  - IDLE to RUN: on `start`. Latch `offset` and clear the issue counter.
  - RUN to DRAIN: after issuing the read for index PIXELS-1.
  - DRAIN to IDLE: when the entry with `out_last` is popped. `done` pulses in the following cycle.
- `start` is ignored in RUN and DRAIN.
- Issue rule: at most one read every 2 cycles. A read is issued only when (FIFO count + in-flight pixels) < FIFO_DEPTH.
  - In-flight covers issued pixels not yet written to the FIFO; at most 3.
  - A stalled issue slot retries each cycle, but 2-cycle spacing is always kept.
- Arithmetic: compute the 17-bit signed `ram_rdata - offset`, then saturate to 16 bits.
  - Results above 32767 clamp to 0x7FFF.
  - Results below -32768 clamp to 0x8000.
- `int_out` loads once per pixel and holds for exactly 2 cycles. The converter needs 2 stable input cycles for a valid result.
- With no pixel pending, `int_out` holds its last value.
- FIFO write: capture `float_in`, index and last flag into the FIFO. Never drop a pixel and never write a pixel twice.
- FIFO semantics:
  - Simultaneous push and pop at full is legal and leaves the count unchanged.
  - Pop occurs on `out_valid && out_ready`.
  - The head is stable while `out_valid && !out_ready`.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame aborts immediately. The FIFO is flushed and in-flight pixels are discarded.
- Reset values: `busy`, `done`, `ram_rd_en` and `out_valid` are 0. `ram_addr`, `int_out`, `out_index`, `out_data` and `out_last` are 0. State is IDLE.

## Timing
Cycle 0 is the cycle in which `start` is sampled high.

- Pixel k:
  - `ram_rd_en`=1 with `ram_addr`=k in cycle 1+2k when unstalled.
  - `ram_rdata` is present in cycle 2+2k.
  - `int_out` carries pixel k in cycles 3+2k and 4+2k.
  - `float_in` is captured at the end of cycle 5+2k.
- Earliest `out_valid` for pixel 0 is cycle 6.
- Sustained throughput is 1 pixel per 2 cycles when `out_ready` is held high.
- For PIXELS=768 with `out_ready` always high:
  - last capture at the end of cycle 1539
  - last `out_valid` in cycle 1540
  - `done` in cycle 1541
  - `busy` is low from cycle 1542.
- `busy` rises in cycle 1.

## Test plan
- Ramp frame (RAM[k]=k-384, offset=0) with `out_ready`=1: 768 outputs in index order. `out_data` equals the IEEE float of k-384 (index 384 gives 0x00000000, index 385 gives 0x3F800000). `out_last` is high only at index 767. `done` pulses in cycle 1541.
- Saturation: RAM[0]=0x7FFF with offset=-2 gives `int_out`=0x7FFF. RAM[1]=0x8000 with offset=1 gives `int_out`=0x8000, held for 2 cycles each.
- Backpressure: hold `out_ready`=0 from cycle 0. FIFO fills to 8, then `ram_rd_en` stops. Release `out_ready`: all 768 pixels arrive exactly once, in order, with no gaps in index.
- Random `out_ready` (50% duty) over a full frame: the output sequence matches a reference model. The in-flight count never exceeds 3 and the FIFO never overflows.
- Assert `start` during RUN: it is ignored, with no restart and no duplicate indices.
- Deassert `resetn` at cycle 400, then restart: all outputs return to reset values asynchronously. After a new `start`, pixel 0 appears again at cycle 6 relative to that `start`.
